// File: rtl/mem_copy_engine_if.sv
// Memory-port bundle between the copy engine and the
// memory controller (via the external arbiter).
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  modport master (
    output mem_address,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator: one read cycle then
// one write cycle per word, with a running checksum.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  mem_copy_engine_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [LEN_WIDTH-1:0]  idx_nx;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] idx_ext;

  assign idx_nx  = idx_q + 1'b1;
  assign idx_ext = {{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, idx_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (length == '0) ? DONE : READ;
      end
      READ: begin
        state_d = abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (abort)
          state_d = IDLE;
        else if (idx_nx == len_q)
          state_d = DONE;
        else
          state_d = READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobe comes straight from a flop so the controller
      // never sees a decode glitch on its write enable.
      we_q    <= (state_d == WRITE);
      if (state_q == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= length;
        idx_q <= '0;
        sum_q <= '0;
      end
      if (state_q == READ && !abort) begin
        buf_q <= bus.mem_rdata;
        sum_q <= sum_q + bus.mem_rdata;
      end
      if (state_q == WRITE)
        idx_q <= idx_nx;
    end
  end

  always_comb begin
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    unique case (1'b1)
      (state_q == READ):  bus.mem_address = src_q + idx_ext;
      (state_q == WRITE): begin
        bus.mem_address = dst_q + idx_ext;
        bus.mem_wdata   = buf_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_we = we_q;
  assign busy       = (state_q == READ) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign checksum   = sum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: memory model with ROM/RAM/unmapped
// regions, table + random copies checked against a copy model.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [5:0]  length = '0;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  mem_copy_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  mem_copy_engine #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .LEN_WIDTH (6)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  // ROM 0x0000-0x003F, RAM 0x0040-0x00BF, everything else unmapped
  logic [31:0] rom   [64];
  logic [31:0] ram   [128];
  logic [31:0] ram_m [128];
  logic [15:0] roff;

  always_comb begin
    roff = bus.mem_address - 16'h0040;
    bus.mem_rdata = '0;
    if (bus.mem_address < 16'h0040)
      bus.mem_rdata = rom[bus.mem_address[5:0]];
    else if (bus.mem_address < 16'h00C0)
      bus.mem_rdata = ram[roff[6:0]];
  end

  always @(posedge clock) begin
    if (bus.mem_we && bus.mem_address >= 16'h0040 &&
        bus.mem_address < 16'h00C0)
      ram[roff[6:0]] <= bus.mem_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [15:0] a);
    logic [15:0] o;
    o = a - 16'h0040;
    if (a < 16'h0040) return rom[a[5:0]];
    if (a < 16'h00C0) return ram_m[o[6:0]];
    return '0;
  endfunction

  function automatic void mwrite(input logic [15:0] a,
                                 input logic [31:0] d);
    logic [15:0] o;
    o = a - 16'h0040;
    if (a >= 16'h0040 && a < 16'h00C0) ram_m[o[6:0]] = d;
  endfunction

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    int          len;
    int          abort_cyc;
    int          restart_cyc;
    int          exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] sum;
    logic [31:0] val;
    logic [15:0] ea;
    logic        eb;
    logic        ed;
    logic        ew;
    int          nw;
    int          last_busy;
    int          lim;
    int          diffs;
    // Reference: the words that finish their write, copied in order
    foreach (ram[i]) ram_m[i] = ram[i];
    nw = (v.abort_cyc == 0) ? v.len : v.abort_cyc / 2;
    sum = '0;
    for (int i = 0; i < nw; i++) begin
      val = mread(v.src + 16'(i));
      mwrite(v.dst + 16'(i), val);
      sum = sum + val;
    end
    last_busy = (v.abort_cyc == 0) ? 2 * v.len : v.abort_cyc;
    lim = 2 * v.len + 3;

    @(negedge clock);
    src_addr = v.src;
    dst_addr = v.dst;
    length   = 6'(v.len);
    start    = 1'b1;
    abort    = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clock);
      eb = (k <= last_busy);
      ed = (k == v.exp_done);
      ew = eb && (k % 2 == 0);
      if (!eb)
        ea = 16'h0000;
      else if (k % 2 == 1)
        ea = v.src + 16'((k - 1) / 2);
      else
        ea = v.dst + 16'(k / 2 - 1);
      check($sformatf("%s cyc%0d busy/done/we/addr", tag, k),
            {45'd0, busy, done, bus.mem_we, bus.mem_address},
            {45'd0, eb, ed, ew, ea});
      abort = (k == v.abort_cyc);
      start = (k == v.restart_cyc);
      if (k == v.restart_cyc) begin
        src_addr = 16'h0033;
        dst_addr = 16'h0099;
        length   = 6'd7;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check({tag, " checksum"}, {32'd0, checksum}, {32'd0, sum});
    diffs = 0;
    foreach (ram[i]) if (ram[i] !== ram_m[i]) diffs++;
    check({tag, " ram diffs"}, 64'(diffs), 64'd0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    foreach (rom[i]) rom[i] = $urandom;
    rom[0] = 32'h0;
    foreach (ram[i]) ram[i] = $urandom;

    tbl[0] = '{16'h0000, 16'h0040, 4, 0, 0, 9};
    tbl[1] = '{16'h0000, 16'h0040, 0, 0, 0, 1};
    tbl[2] = '{16'h0010, 16'h0050, 3, 4, 0, 0};
    tbl[3] = '{16'hFFFF, 16'h0060, 2, 0, 0, 5};
    tbl[4] = '{16'h0020, 16'h0070, 5, 0, 3, 11};
    tbl[5] = '{16'h0040, 16'h0042, 6, 0, 0, 13};
    tbl[6] = '{16'h0008, 16'h0080, 32, 0, 0, 65};

    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset we", 64'(bus.mem_we), 64'd0);
    check("reset addr", 64'(bus.mem_address), 64'd0);
    check("reset wdata", 64'(bus.mem_wdata), 64'd0);
    check("reset checksum", 64'(checksum), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int t = 0; t < 7; t++) begin
      run_vec(tbl[t], $sformatf("tbl%0d", t));
      if (t == 3)
        check("wrap checksum zero", 64'(checksum), 64'd0);
    end

    // async reset during a WRITE cycle
    @(negedge clock);
    src_addr = 16'h0000;
    dst_addr = 16'h0040;
    length   = 6'd3;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre-reset we", 64'(bus.mem_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset we", 64'(bus.mem_we), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset addr", 64'(bus.mem_address), 64'd0);
    check("midreset checksum", 64'(checksum), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_vec('{16'h0004, 16'h0048, 3, 0, 0, 7}, "after_reset");

    for (int r = 0; r < 8; r++) begin
      rv.len = $urandom_range(0, 32);
      rv.src = 16'($urandom_range(0, 16'h00BF));
      rv.dst = 16'($urandom_range(16'h0040, 16'h00C8));
      rv.abort_cyc = 0;
      rv.restart_cyc = 0;
      if (rv.len > 0 && ($urandom % 3) == 0)
        rv.abort_cyc = 2 * $urandom_range(1, rv.len);
      if (rv.len > 1 && ($urandom % 3) == 0)
        rv.restart_cyc = $urandom_range(1, 2 * rv.len - 1);
      rv.exp_done = (rv.abort_cyc == 0) ? 2 * rv.len + 1 : 0;
      if (rv.abort_cyc != 0 && rv.restart_cyc >= rv.abort_cyc)
        rv.restart_cyc = 0;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
